// File: rtl/matrix_tx_formatter_if.sv
// matrix_tx_formatter_if: start/storage/tx bundle of the matrix formatter.
// master = formatter side, slave = environment side.
interface matrix_tx_formatter_if;
  logic        i_start;
  logic [7:0]  i_base_addr;
  logic [31:0] i_m;
  logic [31:0] i_n;
  logic [7:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  modport master (
    input  i_start, i_base_addr, i_m, i_n,
    input  i_rd_data, i_tx_ready,
    output o_rd_addr, o_tx_data, o_tx_valid,
    output o_busy, o_done, o_error
  );

  modport slave (
    output i_start, i_base_addr, i_m, i_n,
    output i_rd_data, i_tx_ready,
    input  o_rd_addr, o_tx_data, o_tx_valid,
    input  o_busy, o_done, o_error
  );
endinterface

// File: rtl/matrix_tx_formatter.sv
// matrix_tx_formatter: streams one stored matrix as decimal ASCII text.
// Option: MATRIX_TX_SIGNED_EN treats elements as 16-bit two's complement.
module matrix_tx_formatter #(
  parameter int MAX_DIM = 5
) (
  input logic clk,
  input logic rst_n,
  matrix_tx_formatter_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD, WAIT, CONV, EMIT, SEP, CR, LF, DONE
  } state_t;

  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;

  state_t          state;
  logic [7:0]      m_r, n_r, row, col;
  logic [15:0]     val;
  logic [4:0][3:0] dig;
  logic [1:0]      step;
  logic [2:0]      ptr;
`ifdef MATRIX_TX_SIGNED_EN
  logic            neg;
  logic            sgn;
`endif

  logic            hs, legal;
  logic [13:0]     p;
  logic [3:0]      d;
  logic [15:0]     rem;
  logic [4:0][3:0] dig_nx;
  logic [2:0]      first;
  logic            unused_hi;

  assign hs = bus.o_tx_valid && bus.i_tx_ready;
  assign unused_hi = ^bus.i_rd_data[31:16];
  assign legal = (bus.i_m >= 32'd1) && (bus.i_m <= 32'(MAX_DIM))
              && (bus.i_n >= 32'd1) && (bus.i_n <= 32'(MAX_DIM));

  function automatic logic [7:0] asc(input logic [3:0] v);
    return {4'h3, v};
  endfunction

  // one decimal place per cycle; last step also yields the ones digit
  always_comb begin
    p = 14'd10;
    unique case (step)
      2'd0: p = 14'd10000;
      2'd1: p = 14'd1000;
      2'd2: p = 14'd100;
      2'd3: p = 14'd10;
    endcase
    d = 4'd0;
    for (int k = 1; k <= 9; k++)
      if ({1'b0, val} >= 17'(k) * {3'b0, p})
        d = 4'(k);
    rem = val - ({12'b0, d} * {2'b0, p});
    dig_nx = dig;
    dig_nx[3'd4 - {1'b0, step}] = d;
    if (step == 2'd3)
      dig_nx[0] = rem[3:0];
    first = 3'd0;
    for (int i = 1; i <= 4; i++)
      if (dig_nx[i] != 4'd0)
        first = 3'(i);
  end

  // formatter FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      m_r            <= '0;
      n_r            <= '0;
      row            <= '0;
      col            <= '0;
      val            <= '0;
      dig            <= '0;
      step           <= '0;
      ptr            <= '0;
`ifdef MATRIX_TX_SIGNED_EN
      neg            <= 1'b0;
      sgn            <= 1'b0;
`endif
      bus.o_rd_addr  <= '0;
      bus.o_tx_data  <= '0;
      bus.o_tx_valid <= 1'b0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_error    <= 1'b0;
    end else begin
      bus.o_done  <= 1'b0;
      bus.o_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            if (legal) begin
              m_r           <= bus.i_m[7:0];
              n_r           <= bus.i_n[7:0];
              row           <= '0;
              col           <= '0;
              bus.o_rd_addr <= bus.i_base_addr;
              bus.o_busy    <= 1'b1;
              state         <= RD;
            end else begin
              bus.o_error <= 1'b1;
            end
          end
        end
        RD: state <= WAIT;
        WAIT: begin
`ifdef MATRIX_TX_SIGNED_EN
          neg <= bus.i_rd_data[15];
          val <= bus.i_rd_data[15]
               ? (~bus.i_rd_data[15:0] + 16'd1)
               : bus.i_rd_data[15:0];
`else
          val <= bus.i_rd_data[15:0];
`endif
          step  <= 2'd0;
          state <= CONV;
        end
        CONV: begin
          val  <= rem;
          dig  <= dig_nx;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            ptr            <= first;
            bus.o_tx_valid <= 1'b1;
            bus.o_tx_data  <= asc(dig_nx[first]);
`ifdef MATRIX_TX_SIGNED_EN
            sgn <= neg;
            if (neg)
              bus.o_tx_data <= 8'h2d;
`endif
            state <= EMIT;
          end
        end
        EMIT: begin
          if (hs) begin
`ifdef MATRIX_TX_SIGNED_EN
            if (sgn) begin
              sgn           <= 1'b0;
              bus.o_tx_data <= asc(dig[ptr]);
            end else
`endif
            if (ptr != 3'd0) begin
              ptr           <= ptr - 3'd1;
              bus.o_tx_data <= asc(dig[ptr - 3'd1]);
            end else if (col == n_r - 8'd1) begin
              bus.o_tx_data <= CH_CR;
              state         <= CR;
            end else begin
              bus.o_tx_data <= CH_SP;
              state         <= SEP;
            end
          end
        end
        SEP: begin
          if (hs) begin
            bus.o_tx_valid <= 1'b0;
            bus.o_rd_addr  <= bus.o_rd_addr + 8'd1;
            col            <= col + 8'd1;
            state          <= RD;
          end
        end
        CR: begin
          if (hs) begin
            bus.o_tx_data <= CH_LF;
            state         <= LF;
          end
        end
        LF: begin
          if (hs) begin
            bus.o_tx_valid <= 1'b0;
            if (row == m_r - 8'd1) begin
              bus.o_done <= 1'b1;
              bus.o_busy <= 1'b0;
              state      <= DONE;
            end else begin
              row           <= row + 8'd1;
              col           <= '0;
              bus.o_rd_addr <= bus.o_rd_addr + 8'd1;
              state         <= RD;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matrix_tx_formatter.md
# matrix_tx_formatter

Reads one matrix out of matrix storage in row-major order, converts each element to decimal ASCII, and streams the text as a byte sequence to the UART byte transmitter. It is the read-side counterpart to the input subsystem, which parses UART text into storage. It sits between the storage mux (display read port) and the UART TX byte sender. A start pulse with base address and dimensions produces exactly one formatted matrix.

## Interface
Parameters:
- `MAX_DIM`, 5: largest legal row/column count.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  single-cycle start request.
- `i_base_addr`  in  8  storage address of element (0,0).
- `i_m`  in  32  row count.
- `i_n`  in  32  column count.
- `o_rd_addr`  out  8  storage read address.
- `i_rd_data`  in  32  storage read data, valid one cycle after `o_rd_addr`.
- `o_tx_data`  out  8  ASCII byte.
- `o_tx_valid`  out  1  byte available.
- `i_tx_ready`  in  1  sender accepts the byte; transfer happens on `o_tx_valid && i_tx_ready`.
- `o_busy`  out  1  high from the accepted start until the done pulse.
- `o_done`  out  1  one-cycle pulse after the final LF transfers.
- `o_error`  out  1  one-cycle pulse when a start is rejected.

## Operation
**Start acceptance**
- `i_start` is sampled only in `IDLE`; starts while busy are ignored.
- Legal dimensions: 1 ≤ `i_m` ≤ `MAX_DIM` and 1 ≤ `i_n` ≤ `MAX_DIM`, using the full 32-bit compare.
- Illegal dimensions: pulse `o_error`, stay `IDLE`, emit no bytes.
- `i_base_addr`, `i_m` and `i_n` are latched at start; later changes to them have no effect.

**Addressing**
- Element (r,c) is read from `base + r*n + c`, computed modulo 256 so addresses wrap past 0xFF.
- The address is computed from row/column counters, not with a multiplier.

**Value conversion**
- Value is `i_rd_data[15:0]`, unsigned 0..65535.
- Digits are produced by repeated subtraction of 10000, 1000, 100 and 10, one subtraction per cycle; the remainder is the ones digit.
- Leading zeros are suppressed; a value of 0 emits `'0'`.
- Digit byte = 0x30 + digit.

**Text format**
- Elements in a row are separated by a single space (0x20). There is no trailing space.
- Each row ends with CR (0x0D) then LF (0x0A).

**States**
- `IDLE` → `RD` (on a legal start).
- `RD`: drive the address → `WAIT`.
- `WAIT`: capture `i_rd_data` → `CONV`.
- `CONV`: digit extraction into a 5-digit buffer → `EMIT`.
- `EMIT`: output the digits → `SEP` if not the last column, else `CR`.
- `SEP` → `RD` (next column).
- `CR` → `LF` → `RD` (next row), or `DONE` after the last row.
- `DONE`: pulse `o_done`, drop `o_busy` → `IDLE`.

**Handshake rules**
- `o_tx_valid` stays asserted until the byte transfers.
- `o_tx_data` is stable while valid and not yet accepted.
- Exactly one byte is transferred per handshake.

## Timing
**Reset values**
- `o_rd_addr`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_busy`=0, `o_done`=0, `o_error`=0, state `IDLE`.

**Reset mid-operation**
- All outputs return to their reset values immediately.
- No partial byte or done pulse is produced after reset releases.

**Latencies**
- Start accepted at edge T: `o_busy`=1 and `o_rd_addr`=base from T+1.
- `o_error` is high for exactly the cycle after a rejected start.
- Per element: 1 cycle `RD`, 1 cycle `WAIT`, 4 cycles `CONV`, then one byte per cycle while `i_tx_ready`=1.
- `o_done` is asserted the cycle after the last LF handshake; `o_busy` falls in the same cycle.

**Boundary conditions**
- `i_tx_ready` held low stalls all progress indefinitely with no byte loss.
- `i_start` in the same cycle as `o_done` is ignored.

## Configuration
- Macro `MATRIX_TX_SIGNED_EN`.
- **Defined:** `i_rd_data[15:0]` is two's complement. Negative values emit `'-'` (0x2D) followed by the magnitude digits. −32768 emits `"-32768"`.
- **Undefined:** values are unsigned as described above, and no sign logic is compiled.

## Test plan
- **2×2 matrix:** base 0x10 holding 1,2,3,4, `i_tx_ready`=1 → bytes `"1 2\r\n3 4\r\n"` (10 bytes), then one `o_done` pulse.
- **Extreme values:** 1×3 matrix holding 0, 65535, 100 → `"0 65535 100\r\n"`. With `MATRIX_TX_SIGNED_EN`, 65535 → `"-1"` instead.
- **Backpressure:** `i_tx_ready` low for 20 cycles mid-digit → `o_tx_valid` and `o_tx_data` stay constant; the full byte stream is unchanged.
- **Illegal dimensions:** `i_m`=0 and `i_n`=6 each → one `o_error` pulse, no `o_tx_valid`, `o_busy` stays 0.
- **Address wrap:** base 0xFE, 1×3 → read addresses 0xFE, 0xFF, 0x00.
- **Reset mid-stream:** `rst_n` low during the second element → all outputs 0 immediately. A new start after release produces the complete correct stream.
